kd_mod_mul: RTL and testbench

KD_MOD_MUL -- requirements
Module: kd_mod_mul

---
 rtl/kd_mod_mul_pkg.sv | 24 ++
 rtl/kd_mod_mul_if.sv | 30 +++
 rtl/kd_barrett_lane.sv | 50 +++++
 rtl/kd_mod_mul.sv | 89 ++++++++
 tb/tb_kd_mod_mul.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/kd_mod_mul_pkg.sv
// Shared constants for the Kyber/Dilithium modular multiplier.
// Moduli, Barrett constants, lane widths, latency and mode encoding.
package kd_pkg;

    localparam int LAT = 5;

    localparam int Kq = 3329;
    localparam int Dq = 8380417;

    // Barrett: t = (x * M) >> K, M = floor(2^K / q)
    localparam int KK = 24;
    localparam int KM = 5039;
    localparam int DK = 46;
    localparam int DM = 8396807;

    localparam int KW = 12;
    localparam int DW = 23;

    typedef enum logic {
        K_MODE = 1'b0,
        D_MODE = 1'b1
    } kd_mode_e;

endpackage

// File: rtl/kd_mod_mul_if.sv
// Beat bus between the butterfly front end and the multiplier.
// master drives operands/mode/valid; slave returns the product.
interface kd_mod_mul_if;

    logic        mul_valid_in;
    logic        KD_mode;
    logic [23:0] mul_a;
    logic [23:0] mul_b;
    logic        mul_valid_out;
    logic [23:0] mul_out;

    modport master (
        output mul_valid_in,
        output KD_mode,
        output mul_a,
        output mul_b,
        input  mul_valid_out,
        input  mul_out
    );

    modport slave (
        input  mul_valid_in,
        input  KD_mode,
        input  mul_a,
        input  mul_b,
        output mul_valid_out,
        output mul_out
    );

endinterface

// File: rtl/kd_barrett_lane.sv
// One modular multiply lane: product, Barrett estimate, remainder.
// Ports: clk, a_i/b_i operands (W bits), r_o reduced result (comb S5).
module kd_barrett_lane #(
    parameter int W = 12,
    parameter int Q = 3329,
    parameter int K = 24,
    parameter int M = 5039
) (
    input  logic         clk,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] r_o
);

    localparam int MW = $clog2(M + 1);
    localparam int XW = 2 * W;
    localparam int PW = XW + MW;
    localparam int TW = PW - K;
    // r < 3q always fits in two bits above the modulus width
    localparam int RW = W + 2;

    localparam logic [MW-1:0] MC = MW'(M);
    localparam logic [RW-1:0] QC = RW'(Q);

    logic [XW-1:0] x_q;
    logic [RW-1:0] xl_q;
    logic [TW-1:0] t_q;
    logic [TW-1:0] t_d;
    logic [RW-1:0] r_q;
    logic [RW-1:0] r_d;
    logic [RW-1:0] s1_d;
    logic [RW-1:0] s2_d;

    assign t_d = TW'((PW'(x_q) * PW'(MC)) >> K);

    // true difference is < 2^RW, so low-bit arithmetic is exact
    assign r_d = xl_q - (RW'(t_q) * QC);

    assign s1_d = (r_q  >= QC) ? r_q  - QC : r_q;
    assign s2_d = (s1_d >= QC) ? s1_d - QC : s1_d;
    assign r_o  = W'(s2_d);

    always_ff @(posedge clk) begin
        x_q  <= XW'(a_i) * XW'(b_i);
        t_q  <= t_d;
        xl_q <= x_q[RW-1:0];
        r_q  <= r_d;
    end

endmodule

// File: rtl/kd_mod_mul.sv
// Dual-mode modular multiplier: two Kyber lanes or one Dilithium lane.
// Ports: clk, rst (sync, high), bus (slave: beat in, product out).
module kd_mod_mul #(
    parameter int LAT = 5
) (
    input  logic            clk,
    input  logic            rst,
    kd_mod_mul_if.slave     bus
);

    import kd_pkg::*;

    // S1..S4 valid/mode stages; the output register is the fifth
    localparam int PD = LAT - 1;

    logic [PD-1:0] vld_q;
    kd_mode_e      mode_q [PD];
    logic [23:0]   a_q;
    logic [23:0]   b_q;
    logic [KW-1:0] kh;
    logic [KW-1:0] kl;
    logic [DW-1:0] dr;
    logic [23:0]   out_d;
    logic [23:0]   out_q;
    logic          vout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[PD-2:0], bus.mul_valid_in};
        end
    end

    always_ff @(posedge clk) begin
        a_q       <= bus.mul_a;
        b_q       <= bus.mul_b;
        mode_q[0] <= kd_mode_e'(bus.KD_mode);
        for (int i = 1; i < PD; i++) begin
            mode_q[i] <= mode_q[i-1];
        end
    end

    kd_barrett_lane #(
        .W(KW), .Q(Kq), .K(KK), .M(KM)
    ) u_k_hi (
        .clk (clk),
        .a_i (a_q[23:12]),
        .b_i (b_q[23:12]),
        .r_o (kh)
    );

    kd_barrett_lane #(
        .W(KW), .Q(Kq), .K(KK), .M(KM)
    ) u_k_lo (
        .clk (clk),
        .a_i (a_q[11:0]),
        .b_i (b_q[11:0]),
        .r_o (kl)
    );

    kd_barrett_lane #(
        .W(DW), .Q(Dq), .K(DK), .M(DM)
    ) u_d (
        .clk (clk),
        .a_i (a_q[22:0]),
        .b_i (b_q[22:0]),
        .r_o (dr)
    );

    assign out_d = (mode_q[PD-1] == D_MODE) ? {1'b0, dr}
                                            : {kh, kl};

    always_ff @(posedge clk) begin
        if (rst) begin
            vout_q <= 1'b0;
            out_q  <= 24'h000000;
        end else begin
            vout_q <= vld_q[PD-1];
            if (vld_q[PD-1]) begin
                out_q <= out_d;
            end
        end
    end

    assign bus.mul_valid_out = vout_q;
    assign bus.mul_out       = out_q;

endmodule

// File: tb/tb_kd_mod_mul.sv
// Directed and random-soak bench for kd_mod_mul.
// Tracks a 5-deep expected pipeline and checks every cycle.
module tb_kd_mod_mul;

    import kd_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    kd_mod_mul_if bus ();

    kd_mod_mul dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    string phase = "init";

    logic        pv [0:4];
    logic        pm [0:4];
    logic [23:0] pd [0:4];
    logic [23:0] last;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s t=%0t got=%0h exp=%0h",
                     phase, tag, $time, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_mul(input logic m,
                                            input logic [23:0] a,
                                            input logic [23:0] b);
        logic [63:0] p;
        logic [63:0] h;
        logic [63:0] l;
        if (m) begin
            p = (64'(a[22:0]) * 64'(b[22:0])) % 64'(Dq);
            return {1'b0, p[22:0]};
        end
        h = (64'(a[23:12]) * 64'(b[23:12])) % 64'(Kq);
        l = (64'(a[11:0]) * 64'(b[11:0])) % 64'(Kq);
        return {h[11:0], l[11:0]};
    endfunction

    task automatic tick(input logic v, input logic m,
                        input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] e);
        logic ok;
        bus.mul_valid_in = v;
        bus.KD_mode      = m;
        bus.mul_a        = a;
        bus.mul_b        = b;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                pv[i] = 1'b0;
                pm[i] = 1'b0;
                pd[i] = 24'h0;
            end
            last = 24'h0;
        end else begin
            for (int i = 4; i > 0; i--) begin
                pv[i] = pv[i-1];
                pm[i] = pm[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = v;
            pm[0] = m;
            pd[0] = e;
            if (pv[4]) last = pd[4];
        end
        chk("vout", 32'(bus.mul_valid_out), 32'(pv[4]));
        chk("out", 32'(bus.mul_out), 32'(last));
        if (pv[4]) begin
            if (pm[4])
                ok = bus.mul_out < 24'(Dq);
            else
                ok = (bus.mul_out[23:12] < 12'(Kq)) &&
                     (bus.mul_out[11:0] < 12'(Kq));
            chk("range", 32'(ok), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
        end
    endtask

    initial begin
        logic        m;
        logic [23:0] a;
        logic [23:0] b;

        rst = 1'b1;
        phase = "reset";
        idle(3);

        // first beat in the first cycle with rst low
        rst = 1'b0;
        phase = "kwrap";
        tick(1'b1, 1'b0, {12'd3328, 12'd3328},
             {12'd3328, 12'd3328}, {12'd1, 12'd1});
        phase = "klanes";
        tick(1'b1, 1'b0, {12'd1665, 12'd4095},
             {12'd2, 12'd4095}, {12'd1, 12'd852});
        phase = "dwrap";
        tick(1'b1, 1'b1, 24'd8380416, 24'd8380416, 24'd1);
        phase = "dtop";
        tick(1'b1, 1'b1, 24'h800001, 24'h000002, 24'd2);
        phase = "dover";
        tick(1'b1, 1'b1, 24'h7FFFFF, 24'h7FFFFF, 24'd32764);
        phase = "kover";
        tick(1'b1, 1'b0, {12'hFFF, 12'd0},
             {12'd1, 12'd5}, {12'd766, 12'd0});
        phase = "kzero";
        tick(1'b1, 1'b0, 24'h000000, 24'hABCDEF, 24'h000000);
        phase = "flush1";
        idle(6);

        phase = "midrst";
        tick(1'b1, 1'b0, {12'd5, 12'd7}, {12'd9, 12'd11},
             {12'd45, 12'd77});
        tick(1'b1, 1'b1, 24'd1000, 24'd1000, 24'd1000000);
        tick(1'b1, 1'b0, {12'd3, 12'd3}, {12'd3, 12'd3},
             {12'd9, 12'd9});
        rst = 1'b1;
        tick(1'b1, 1'b1, 24'd7, 24'd7, 24'd49);
        rst = 1'b0;
        phase = "postrst";
        idle(8);

        phase = "mixed";
        for (int i = 0; i < 12; i++) begin
            if (i == 6 || i == 7) begin
                idle(1);
            end else begin
                m = 1'(i % 2);
                a = 24'(32'h00A5A5 * (i + 3) + 32'h123456 * i);
                b = 24'(32'h3C0FFE + 32'h011111 * i);
                tick(1'b1, m, a, b, ref_mul(m, a, b));
            end
        end
        idle(6);

        phase = "soak";
        for (int i = 0; i < 3000; i++) begin
            m = 1'($urandom_range(0, 1));
            a = 24'($urandom());
            b = 24'($urandom());
            if ($urandom_range(0, 7) == 0)
                a = m ? 24'(Dq - 1) : {12'(Kq - 1), 12'hFFF};
            tick(1'($urandom_range(0, 4) != 0), m, a, b,
                 ref_mul(m, a, b));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
